// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the memory stage and a word-wide
// valid/ready data memory. Accepts one byte/half/word request at a time,
// flags misaligned or reserved-size requests, issues word-aligned accesses
// and returns sign/zero-extended load data.
// Ports: clk, reset_n (async, active low); req_* request handshake in;
// resp_* one-cycle response pulse out; mem_* memory transaction out,
// mem_ready/mem_rdata in.
// Build option: define LSU_RMW_EN to merge sub-word stores by
// read-modify-write (mem_be always 1111); otherwise a single write with
// partial byte enables is issued.
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD, WR, RMW_RD, RMW_WR, RESP
  } state_t;

`ifdef LSU_RMW_EN
  localparam state_t SUB_ST = RMW_RD;
`else
  localparam state_t SUB_ST = WR;
`endif

  state_t state, state_n;

  logic              we_q;
  logic              uns_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  // Holds extended load data, or the merged word in the RMW path.
  logic [31:0]       word_q;

  logic        mis;
  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] ld_ext;
  logic [31:0] rep;
  logic [31:0] mask;
  logic [31:0] merged;
  logic [3:0]  be_wr;
  logic [ADDR_W-1:0] waddr;

  always_comb begin
    mis = (req_size == 2'b11)
        | ((req_size == 2'b01) & req_addr[0])
        | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    waddr = {addr_q[ADDR_W-1:2], 2'b00};
    if (size_q == 2'b00) sh = {addr_q[1:0], 3'b000};
    else                 sh = {addr_q[1], 4'b0000};
    lane = 16'(mem_rdata >> sh);
    case (size_q)
      2'b00: begin
        ld_ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
        rep    = {4{wdata_q[7:0]}};
        mask   = 32'h0000_00ff << sh;
        be_wr  = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        ld_ext = {{16{~uns_q & lane[15]}}, lane};
        rep    = {2{wdata_q[15:0]}};
        mask   = 32'h0000_ffff << sh;
        be_wr  = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: begin
        ld_ext = mem_rdata;
        rep    = wdata_q;
        mask   = 32'hffff_ffff;
        be_wr  = 4'b1111;
      end
    endcase
    // Replicated store data already sits in the right lane.
    merged = (mem_rdata & ~mask) | (rep & mask);
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (mis)                     state_n = RESP;
          else if (!req_we)            state_n = RD;
          else if (req_size == 2'b10)  state_n = WR;
          else                         state_n = SUB_ST;
        end
      end
      RD, RMW_RD: begin
        mem_valid = 1'b1;
        mem_addr  = waddr;
        mem_be    = 4'b1111;
        if (mem_ready) state_n = (state == RD) ? RESP : RMW_WR;
      end
      WR: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = waddr;
        mem_wdata = rep;
        mem_be    = be_wr;
        if (mem_ready) state_n = RESP;
      end
      RMW_WR: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = waddr;
        mem_wdata = word_q;
        mem_be    = 4'b1111;
        if (mem_ready) state_n = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q | err_q) ? 32'd0 : word_q;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= mis;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        word_q  <= '0;
      end
      if (state == RD && mem_ready)     word_q <= ld_ext;
      if (state == RMW_RD && mem_ready) word_q <= merged;
    end
  end

endmodule
